// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared state encoding, pointer reset value and counter width
//               for the four-requester round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Pointing at requester 3 makes requester 0 the first in line after reset.
    localparam logic [1:0] LAST_RESET = 2'd3;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational round-robin picker; scans last+1 .. last (mod 4)
//               over req with masked bits removed and reports the first hit.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    input  logic [3:0] mask,
    output logic       any,
    output logic [1:0] winner
);

    logic [3:0] cand;
    logic [1:0] idx;

    assign cand = req & ~mask;

    always_comb begin
        any    = 1'b0;
        winner = last;
        idx    = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!any && cand[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4
// Description : Four-requester round-robin arbiter driving mux sel/enable with
//               burst hold and zero-bubble handover. Burst limit compiled in
//               with macro RR_ARB_BURST_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4
    import rr_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic       enable,
    output logic [3:0] gnt,
    output logic [3:0] ack,
    output logic       out_valid
);

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("rr_arbiter_4: MAX_BURST must be in 1..255");
    end

    arb_state_t state;
    arb_state_t next_state;
    logic [1:0] last;
    logic       holder_req;
    logic       drop_release;
    logic       limit_hit;
    logic       release_grant;
    logic       load_grant;
    logic [3:0] pick_mask;
    logic       pick_any;
    logic [1:0] pick_winner;

    assign holder_req   = req[sel];
    assign drop_release = (state == ST_GRANT) && !holder_req;

`ifdef RR_ARB_BURST_LIMIT_EN
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] beat_cnt;
    logic             beat;

    assign beat      = (state == ST_GRANT) && holder_req && out_ready;
    assign limit_hit = beat && (beat_cnt == BURST_LAST);
`else
    assign limit_hit = 1'b0;
`endif

    assign release_grant = drop_release || limit_hit;

    // A limit release keeps the holder eligible so a sole requester is re-granted.
    assign pick_mask = drop_release ? onehot4(sel) : 4'b0000;

    rr_pick4 u_pick (
        .req    (req),
        .last   (last),
        .mask   (pick_mask),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_grant = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    next_state = ST_GRANT;
                    load_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (release_grant) begin
                    if (pick_any) begin
                        load_grant = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        enable    = (state == ST_GRANT);
        gnt       = (state == ST_GRANT) ? onehot4(sel) : 4'b0000;
        ack       = gnt & {4{out_ready}};
        out_valid = (state == ST_GRANT) && holder_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= 2'd0;
            last <= LAST_RESET;
        end else if (load_grant) begin
            sel  <= pick_winner;
            last <= pick_winner;
        end
    end

`ifdef RR_ARB_BURST_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (load_grant) begin
            beat_cnt <= '0;
        end else if (beat && (beat_cnt != CNT_MAX)) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_4
// Description : Directed self-checking bench for rr_arbiter_4; expectations
//               follow RR_ARB_BURST_LIMIT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] sel;
    logic       enable;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .enable    (enable),
        .gnt       (gnt),
        .ack       (ack),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic en, input logic [1:0] s);
        logic [3:0] g;
        g = en ? (4'b0001 << s) : 4'b0000;
        check({tag, "/enable"}, 8'(enable), 8'(en));
        if (en) check({tag, "/sel"}, 8'(sel), 8'(s));
        check({tag, "/gnt"}, 8'(gnt), 8'(g));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst/sel", 8'(sel), 8'd0);
        check_grant("rst", 1'b0, 2'd0);
        check("rst/ack", 8'(ack), 8'h0);
        check("rst/out_valid", 8'(out_valid), 8'h0);

`ifdef RR_ARB_BURST_LIMIT_EN
        // All four requesting: 4 beats each, rotating with no idle cycle.
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_grant($sformatf("rot%0d", k), 1'b1, 2'((k / 4) % 4));
            check($sformatf("rot%0d/ack", k), 8'(ack), 8'(4'b0001 << ((k / 4) % 4)));
        end
`else
        req   = 4'b0011;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_grant($sformatf("hold%0d", k), 1'b1, 2'd0);
            check($sformatf("hold%0d/ack", k), 8'(ack), 8'h01);
        end
        req = 4'b0010;
        #1;
        check("drop0/out_valid", 8'(out_valid), 8'h0);
        tick();
        check_grant("drop0/next", 1'b1, 2'd1);
`endif

        // Holder 1 drops after two beats while 3 waits.
        req       = 4'b1010;
        out_ready = 1'b1;
        do_reset();
        tick();
        check_grant("h1/a", 1'b1, 2'd1);
        check("h1/a/ack", 8'(ack), 8'h02);
        tick();
        check_grant("h1/b", 1'b1, 2'd1);
        tick();
        req = 4'b1001;
        #1;
        check("h1/drop/out_valid", 8'(out_valid), 8'h0);
        check("h1/drop/ack", 8'(ack), 8'h02);
        tick();
        check_grant("h1/next", 1'b1, 2'd3);
`ifdef RR_ARB_BURST_LIMIT_EN
        for (int k = 1; k < 4; k++) begin
            tick();
            check_grant($sformatf("h3/%0d", k), 1'b1, 2'd3);
        end
        tick();
        check_grant("h3/rotate", 1'b1, 2'd0);
`else
        for (int k = 1; k < 6; k++) begin
            tick();
            check_grant($sformatf("h3/%0d", k), 1'b1, 2'd3);
        end
`endif

        // Stall mid-burst: five cycles of out_ready low freeze the beat count.
        req       = 4'b1100;
        out_ready = 1'b1;
        do_reset();
        tick();
        check_grant("stall/start", 1'b1, 2'd2);
        tick();
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall%0d/ack", k), 8'(ack), 8'h0);
            check($sformatf("stall%0d/out_valid", k), 8'(out_valid), 8'h1);
            check_grant($sformatf("stall%0d", k), 1'b1, 2'd2);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("stall/resume/ack", 8'(ack), 8'h04);
        tick();
        check_grant("stall/beat3", 1'b1, 2'd2);
        tick();
`ifdef RR_ARB_BURST_LIMIT_EN
        check_grant("stall/done", 1'b1, 2'd3);
`else
        check_grant("stall/done", 1'b1, 2'd2);
`endif

        // Sole requester keeps the grant with enable never dropping.
        req = 4'b0100;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            tick();
            check_grant($sformatf("sole%0d", k), 1'b1, 2'd2);
        end

        // Asynchronous reset mid-burst, between clock edges.
        req = 4'b1100;
        do_reset();
        tick();
        check_grant("areset/pre", 1'b1, 2'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("areset/sel", 8'(sel), 8'd0);
        check_grant("areset", 1'b0, 2'd0);
        check("areset/ack", 8'(ack), 8'h0);
        check("areset/out_valid", 8'(out_valid), 8'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_grant("areset/post", 1'b1, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that sits directly upstream of the 4-input bus multiplexer and drives its `sel` and `enable` inputs. It grants one requester at a time, holds the grant for a burst of beats under a valid/ready handshake with the downstream consumer, and rotates priority so that no requester starves. All grant state is registered, so the multiplexer select is glitch-free and stable for a whole burst.

## Interface
- `MAX_BURST`, default 4: maximum beats per grant when the burst limit is compiled in; legal range 1..255.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 4: per-requester request; bit i means requester i has data on mux input i.
- `out_ready` input 1: downstream accepts the current beat.
- `sel` output 2: registered; drives mux `sel`.
- `enable` output 1: registered; drives mux `enable`; high while a grant is held.
- `gnt` output 4: one-hot of `sel` when `enable`=1, else 0.
- `ack` output 4: `gnt & {4{out_ready}}`; combinational; tells requester i its beat was taken.
- `out_valid` output 1: `enable & req[sel]`; combinational; qualifies the mux output.

## Operation
- States: IDLE (`enable`=0), GRANT (`enable`=1). Encoding comes from the shared package.
- Priority pointer `last` (2 bits): index of the most recent grant holder. The search order is `last+1, last+2, last+3, last` (mod 4). The first asserted `req` in that order wins.
- IDLE: if `req`≠0, go to GRANT next cycle with `sel`=winner, `last`=winner, and `beat_cnt`=0. Otherwise stay in IDLE.
- GRANT: a beat is a cycle with `out_valid & out_ready`. On each beat, `beat_cnt` increments (8-bit, saturating at 255).
- Release condition: `req[sel]`=0, or (with the limit compiled in) a beat occurs while `beat_cnt`=`MAX_BURST-1`.
- On release, re-arbitrate in the same cycle using current `req`, with the released index masked if its `req`=0. If a winner exists, the next cycle is GRANT with the new `sel`, `last` updated, and `beat_cnt`=0. There is no bubble cycle. If there is no winner, go to IDLE.
- Sole requester hitting the burst limit is re-granted immediately: same `sel`, `beat_cnt` restarts at 0.
- A requester dropping `req` mid-burst with no beat that cycle releases the grant; beats already counted are not carried over.
- `out_ready` low stalls the burst: grant held, counter frozen.
- Reset, from any state: IDLE, `sel`=0, `enable`=0, `gnt`=0, `last`=3 (requester 0 has top priority first), `beat_cnt`=0. `ack` and `out_valid` are 0 because `enable`=0.

## Timing
- Arbitration latency is 1 cycle: `req` rising in IDLE at edge N gives `enable`/`sel` valid after edge N+1.
- Handover latency is 0 bubble cycles: the release cycle's edge loads the next holder.
- `ack` and `out_valid` follow `req`/`out_ready` combinationally in the same cycle. `sel`/`enable`/`gnt` change only on clock edges or on asynchronous reset.
- Maximum throughput is 1 beat per cycle, including across grant boundaries.

## Configuration
- `RR_ARB_BURST_LIMIT_EN` defined: the burst counter is active, and a grant is released after `MAX_BURST` beats or when `req[sel]` drops.
- `RR_ARB_BURST_LIMIT_EN` not defined: `beat_cnt` and `MAX_BURST` checks are removed. A grant is held until `req[sel]` drops, so a requester may hold the mux indefinitely.

## Structure
- Package `rr_arb_pkg`: state encoding (IDLE=1'b0, GRANT=1'b1), pointer reset value 2'd3, counter width 8.
- Sub-module `rr_pick4`: purely combinational. Inputs are `req[3:0]`, `last[1:0]`, and `mask[3:0]`. Outputs are `any` and `winner[1:0]`. It is instantiated once and shared by the IDLE and release paths.
- The top level holds the state register, `sel`/`last`/`beat_cnt` registers, and output assigns.

## Test plan
- Reset, then `req`=4'b1111 with `out_ready`=1 and limit on (`MAX_BURST`=4) → grants 0,1,2,3,0 in turn, each exactly 4 beats, no idle cycle between grants.
- `req`=4'b0100 only, limit on, `MAX_BURST`=2 → `sel`=2 continuously, `beat_cnt` wraps 0,1,0,1, `enable` never drops.
- Holder 1 drops `req` after 2 beats while `req[3]`=1 → next cycle `sel`=3, `gnt`=4'b1000, `beat_cnt`=0.
- `out_ready`=0 for 5 cycles mid-burst → `sel` unchanged, `ack`=0, counter frozen; burst completes after `out_ready` returns.
- Assert `rst_n`=0 asynchronously mid-burst (`sel`=2) → `enable`/`gnt`/`sel` go to 0 before the next edge; after release with `req`=4'b1100, the first grant is `sel`=2.
- Build without `RR_ARB_BURST_LIMIT_EN`, `req`=4'b0011 held for 20 beats → `sel`=0 for all 20 beats; when `req[0]` drops, the next cycle `sel`=1.
